regfile_mp: RTL and testbench

//   Parametrised multi-write-port register file with write-to-read bypass, per-register busy

---
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// =============================================================================
// regfile_mp_if : write/read/issue/clear bundle for the regfile_mp register file
// Rev 1.0
// =============================================================================
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we_a;
  logic [ADDR_W-1:0] wa_a;
  logic [WIDTH-1:0]  wd_a;
  logic              we_b;
  logic [ADDR_W-1:0] wa_b;
  logic [WIDTH-1:0]  wd_b;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              busy1;
  logic              busy2;
  logic              iss_v;
  logic [ADDR_W-1:0] iss_addr;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra1, ra2, iss_v, iss_addr, clr_req,
    input  rd1, rd2, busy1, busy2, clr_busy
  );

  modport slave (
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra1, ra2, iss_v, iss_addr, clr_req,
    output rd1, rd2, busy1, busy2, clr_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// =============================================================================
// regfile_mp : dual-write register file with bypass, busy scoreboard, clear sweep
// Rev 1.0
// =============================================================================
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input wire          clk,
  input wire          rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic idle;
  logic wr_a_ok;
  logic wr_b_ok;
  logic iss_ok;

  // Writes and issues to the hardwired-zero entry are dropped here so the
  // array, scoreboard and bypass all see a single qualified enable.
  assign idle    = (state_q == ST_IDLE);
  assign wr_a_ok = idle && bus.we_a  && !(ZERO_REG && (bus.wa_a == '0));
  assign wr_b_ok = idle && bus.we_b  && !(ZERO_REG && (bus.wa_b == '0));
  assign iss_ok  = idle && bus.iss_v && !(ZERO_REG && (bus.iss_addr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Port B is applied after port A and the issue set after both, so the
  // later assignment carries the priority on address collisions.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (!idle) begin
      mem_d[ptr_q]  = '0;
      busy_d[ptr_q] = 1'b0;
    end else begin
      if (wr_a_ok) begin
        mem_d[bus.wa_a]  = bus.wd_a;
        busy_d[bus.wa_a] = 1'b0;
      end
      if (wr_b_ok) begin
        mem_d[bus.wa_b]  = bus.wd_b;
        busy_d[bus.wa_b] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[bus.iss_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  function automatic logic [WIDTH-1:0] read_mux(input logic [ADDR_W-1:0] ra);
    logic [WIDTH-1:0] val;
    val = mem_q[ra];
    if (ZERO_REG && (ra == '0)) begin
      val = '0;
    end else if (wr_b_ok && (bus.wa_b == ra)) begin
      val = bus.wd_b;
    end else if (wr_a_ok && (bus.wa_a == ra)) begin
      val = bus.wd_a;
    end
    return val;
  endfunction

  assign bus.rd1      = read_mux(bus.ra1);
  assign bus.rd2      = read_mux(bus.ra2);
  assign bus.busy1    = busy_q[bus.ra1];
  assign bus.busy2    = busy_q[bus.ra2];
  assign bus.clr_busy = !idle;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// =============================================================================
// tb_regfile_mp : directed bench for regfile_mp, ZERO_REG=1 and ZERO_REG=0 side by side
// Rev 1.0
// =============================================================================
module tb_regfile_mp;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic rst_n;

  logic              we_a, we_b, iss_v, clr_req;
  logic [ADDR_W-1:0] wa_a, wa_b, ra1, ra2, iss_addr;
  logic [WIDTH-1:0]  wd_a, wd_b;

  int errors;
  int checks;

  regfile_mp_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if0 ();
  regfile_mp_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if1 ();

  assign if0.we_a = we_a;   assign if1.we_a = we_a;
  assign if0.wa_a = wa_a;   assign if1.wa_a = wa_a;
  assign if0.wd_a = wd_a;   assign if1.wd_a = wd_a;
  assign if0.we_b = we_b;   assign if1.we_b = we_b;
  assign if0.wa_b = wa_b;   assign if1.wa_b = wa_b;
  assign if0.wd_b = wd_b;   assign if1.wd_b = wd_b;
  assign if0.ra1  = ra1;    assign if1.ra1  = ra1;
  assign if0.ra2  = ra2;    assign if1.ra2  = ra2;
  assign if0.iss_v    = iss_v;    assign if1.iss_v    = iss_v;
  assign if0.iss_addr = iss_addr; assign if1.iss_addr = iss_addr;
  assign if0.clr_req  = clr_req;  assign if1.clr_req  = clr_req;

  regfile_mp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  regfile_mp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index k=0 is the ordinary file, k=1 has a hardwired r0.
  // m_left counts the sweep cycles still to run; entry DEPTH-m_left is zeroed next.
  logic [WIDTH-1:0] m_mem  [2][DEPTH];
  logic             m_busy [2][DEPTH];
  int               m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[k][i]  <= '0;
          m_busy[k][i] <= 1'b0;
        end
      end
    end else if (m_left > 0) begin
      for (int k = 0; k < 2; k++) begin
        m_mem[k][DEPTH - m_left]  <= '0;
        m_busy[k][DEPTH - m_left] <= 1'b0;
      end
      m_left <= m_left - 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we_a && !(k == 1 && wa_a == 0)) begin
          m_mem[k][wa_a]  <= wd_a;
          m_busy[k][wa_a] <= 1'b0;
        end
        if (we_b && !(k == 1 && wa_b == 0)) begin
          m_mem[k][wa_b]  <= wd_b;
          m_busy[k][wa_b] <= 1'b0;
        end
        if (iss_v && !(k == 1 && iss_addr == 0)) begin
          m_busy[k][iss_addr] <= 1'b1;
        end
      end
      if (clr_req) m_left <= DEPTH;
    end
  end

  function automatic logic [WIDTH-1:0] exp_rd(input int k, input logic [ADDR_W-1:0] ra);
    if (k == 1 && ra == 0) return '0;
    if (m_left == 0) begin
      if (we_b && wa_b == ra) return wd_b;
      if (we_a && wa_a == ra) return wd_a;
    end
    return m_mem[k][ra];
  endfunction

  task automatic chk(input string name, input int k, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s zero_reg=%0d t=%0t got=%h expected=%h", name, k, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rd1",      0, if0.rd1,      exp_rd(0, ra1));
    chk("rd2",      0, if0.rd2,      exp_rd(0, ra2));
    chk("busy1",    0, 32'(if0.busy1),    32'(m_busy[0][ra1]));
    chk("busy2",    0, 32'(if0.busy2),    32'(m_busy[0][ra2]));
    chk("clr_busy", 0, 32'(if0.clr_busy), 32'(m_left > 0));
    chk("rd1",      1, if1.rd1,      exp_rd(1, ra1));
    chk("rd2",      1, if1.rd2,      exp_rd(1, ra2));
    chk("busy1",    1, 32'(if1.busy1),    32'(m_busy[1][ra1]));
    chk("busy2",    1, 32'(if1.busy2),    32'(m_busy[1][ra2]));
    chk("clr_busy", 1, 32'(if1.clr_busy), 32'(m_left > 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_a = 1'b0; we_b = 1'b0; iss_v = 1'b0; clr_req = 1'b0;
    wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; iss_addr = '0;
  endtask

  int cnt;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    ra1 = 5'd5;
    ra2 = 5'd0;
    repeat (3) step();
    chk("reset_rd1",      1, if1.rd1, 32'h0);
    chk("reset_busy1",    1, 32'(if1.busy1), 32'h0);
    chk("reset_clr_busy", 1, 32'(if1.clr_busy), 32'h0);
    rst_n = 1'b1;
    step();

    // write port A, bypass then stored
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1234; ra1 = 5'd5;
    #1 chk("bypass_a", 1, if1.rd1, 32'h1234);
    step(); we_a = 1'b0;
    #1 chk("stored_a", 1, if1.rd1, 32'h1234);

    // both ports to r7, B wins
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hAAAA;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'hBBBB;
    ra1 = 5'd7; ra2 = 5'd7;
    #1 chk("bypass_b_wins", 1, if1.rd1, 32'hBBBB);
    step(); we_a = 1'b0; we_b = 1'b0;
    #1 chk("stored_b_wins", 1, if1.rd2, 32'hBBBB);

    // register 0 behaviour in both configurations
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1 chk("r0_bypass", 1, if1.rd1, 32'h0);
    chk("r0_bypass", 0, if0.rd1, 32'hFFFF);
    step(); we_a = 1'b0; iss_v = 1'b1; iss_addr = 5'd0;
    #1 chk("r0_stored", 1, if1.rd1, 32'h0);
    chk("r0_stored", 0, if0.rd1, 32'hFFFF);
    step(); iss_v = 1'b0;
    #1 chk("r0_busy", 1, 32'(if1.busy2), 32'h0);
    chk("r0_busy", 0, 32'(if0.busy2), 32'h1);

    // scoreboard set / set-wins / clear
    iss_v = 1'b1; iss_addr = 5'd3; ra2 = 5'd3;
    step(); iss_v = 1'b0;
    #1 chk("iss_busy", 1, 32'(if1.busy2), 32'h1);
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h33; iss_v = 1'b1; iss_addr = 5'd3;
    step(); we_a = 1'b0; iss_v = 1'b0;
    #1 chk("iss_wr_set_wins", 1, 32'(if1.busy2), 32'h1);
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h34;
    step(); we_a = 1'b0;
    #1 chk("wr_clears_busy", 1, 32'(if1.busy2), 32'h0);
    chk("wr_data", 1, if1.rd2, 32'h34);

    // fill r1..r31 with busy set, then sweep
    for (int i = 1; i < DEPTH; i++) begin
      we_a = 1'b1; wa_a = 5'(i); wd_a = 32'h100 + 32'(i);
      iss_v = 1'b1; iss_addr = 5'(i);
      step();
    end
    idle_inputs();
    ra1 = 5'd20;
    #1 chk("fill_r20", 1, if1.rd1, 32'h114);
    chk("fill_busy20", 1, 32'(if1.busy1), 32'h1);
    clr_req = 1'b1;
    step(); clr_req = 1'b0;
    #1 chk("sweep_start", 1, 32'(if1.clr_busy), 32'h1);
    cnt = 0;
    while (if1.clr_busy && cnt < 100) begin
      cnt++;
      we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hDEAD;
      we_b = 1'b1; wa_b = 5'd9; wd_b = 32'hBEEF;
      iss_v = 1'b1; iss_addr = 5'd12; clr_req = 1'b1; ra1 = 5'd9;
      step();
    end
    idle_inputs();
    chk("sweep_len", 1, 32'(cnt), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = 5'(i);
      #1 chk("post_sweep_rd", 1, if1.rd1, 32'h0);
      chk("post_sweep_rd", 0, if0.rd1, 32'h0);
      chk("post_sweep_busy", 1, 32'(if1.busy1), 32'h0);
    end
    step();

    // reset in the middle of a sweep
    we_a = 1'b1; wa_a = 5'd20; wd_a = 32'h77;
    we_b = 1'b1; wa_b = 5'd25; wd_b = 32'h88;
    step(); idle_inputs(); clr_req = 1'b1;
    step(); clr_req = 1'b0;
    repeat (9) step();
    ra1 = 5'd20; ra2 = 5'd25;
    #1 chk("mid_sweep_r20", 1, if1.rd1, 32'h77);
    rst_n = 1'b0;
    #1 chk("rst_clr_busy", 1, 32'(if1.clr_busy), 32'h0);
    chk("rst_r20", 1, if1.rd1, 32'h0);
    chk("rst_r25", 0, if0.rd2, 32'h0);
    #2 rst_n = 1'b1;
    step();
    we_a = 1'b1; wa_a = 5'd20; wd_a = 32'h55;
    step(); we_a = 1'b0;
    #1 chk("post_rst_write", 1, if1.rd1, 32'h55);
    chk("post_rst_idle", 1, 32'(if1.clr_busy), 32'h0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
